// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  // Controller states: stopped, running, running with a ratio change queued.
  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } div_state_e;

  // Smallest divide ratio that still yields a high and a low phase.
  localparam int unsigned DIV_MIN     = 2;
  localparam int unsigned DIV_RST_DEF = 2;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle between a requester and the clock divider.
interface clk_div_ctrl_if #(
  parameter int unsigned DIV_W = 4
);
  logic             en;
  logic             cfg_req;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ack;
  logic             cfg_err;
  logic             clk_out;
  logic             busy;
  logic [DIV_W-1:0] div_cur;

  modport master (
    output en, cfg_req, cfg_div,
    input  cfg_ack, cfg_err, clk_out, busy, div_cur
  );

  modport slave (
    input  en, cfg_req, cfg_div,
    output cfg_ack, cfg_err, clk_out, busy, div_cur
  );
endinterface

// File: rtl/clk_div_core.sv
// Period counter and registered divided-clock output.
module clk_div_core #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             at_boundary,
  output logic             clk_out
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic [DIV_W:0]   half;

  // Next count and next output level; high while cnt < ceil(div/2).
  always_comb begin
    half        = ({1'b0, div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    at_boundary = (cnt_q == div - 1'b1);
    cnt_d       = '0;
    clk_out_d   = 1'b0;
    if (run) begin
      if (load || at_boundary) begin
        cnt_d     = '0;
        clk_out_d = 1'b1;
      end else begin
        cnt_d     = cnt_q + 1'b1;
        clk_out_d = ({1'b0, cnt_d} < half);
      end
    end
  end

  // Counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: run/stop FSM, ratio handshake and ratio registers.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = 4,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input logic           clk,
  input logic           rst_n,
  clk_div_ctrl_if.slave bus
);

  localparam logic [DIV_W-1:0] DivMin = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] DivRst = DIV_W'(DIV_RST);

  div_state_e       st_q, st_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_nxt_q, div_nxt_d;
  logic             ack_q, err_q;
  logic             done_q, done_d;
  logic             req_new, req_ok, req_bad, accept;
  logic             core_bnd, bnd, run, load;

  // Request decode; done_q blocks a held request from being answered twice.
  always_comb begin
    req_new = bus.cfg_req && !done_q;
    req_ok  = req_new && (bus.cfg_div >= DivMin);
    req_bad = req_new && (bus.cfg_div < DivMin);
    accept  = req_ok && (st_q != StPend);
    bnd     = core_bnd && (st_q != StOff);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= StOff;
    else        st_q <= st_d;
  end

  // Next state: stops and ratio changes only take effect on a period boundary.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StOff: begin
        if (bus.en) st_d = StRun;
      end
      StRun: begin
        if (bnd && !bus.en) st_d = StOff;
        else if (accept)    st_d = StPend;
      end
      StPend: begin
        if (bnd) st_d = bus.en ? StRun : StOff;
      end
      default: st_d = StOff;
    endcase
  end

  // FSM outputs: core control and busy flag.
  always_comb begin
    run      = (st_d != StOff);
    load     = (st_q == StOff);
    bus.busy = (st_q == StPend);
  end

  // Ratio registers; a request accepted while stopped (or stopping) lands directly.
  always_comb begin
    div_cur_d = div_cur_q;
    div_nxt_d = div_nxt_q;
    done_d    = bus.cfg_req ? (done_q || accept || req_bad) : 1'b0;
    unique case (st_q)
      StOff: begin
        if (accept) div_cur_d = bus.cfg_div;
      end
      StRun: begin
        if (accept) begin
          if (bnd && !bus.en) div_cur_d = bus.cfg_div;
          else                div_nxt_d = bus.cfg_div;
        end
      end
      StPend: begin
        if (bnd) div_cur_d = div_nxt_q;
      end
      default: ;
    endcase
  end

  // Handshake pulses and ratio state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cur_q <= DivRst;
      div_nxt_q <= DivRst;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      div_cur_q <= div_cur_d;
      div_nxt_q <= div_nxt_d;
      ack_q     <= accept;
      err_q     <= req_bad;
      done_q    <= done_d;
    end
  end

  assign bus.cfg_ack = ack_q;
  assign bus.cfg_err = err_q;
  assign bus.div_cur = div_cur_q;

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .load        (load),
    .div         (div_cur_q),
    .at_boundary (core_bnd),
    .clk_out     (bus.clk_out)
  );

endmodule
